// File: rtl/regfile_hilo.sv
// regfile_hilo: MIPS architectural state, 32 GPRs plus HI/LO.
// The GPRs have two combinational read ports with a same-cycle write-back
// bypass. HI/LO are registered only and have no bypass.
module regfile_hilo #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic          hilo_we,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam int unsigned NREG = 1 << AW;

  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic          w_wr_en;

  // $0 is never written, so it holds the zero it gets at reset
  assign w_wr_en = we && (waddr != '0);

  // GPR storage: clear on reset, otherwise take the write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  // HI/LO pair: written together, never partially
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (hilo_we) begin
      r_hi <= hi_i;
      r_lo <= lo_i;
    end
  end

  // Read port 1: reset, $0 and disable force zero; a matching write is bypassed
  always_comb begin
    rdata1 = '0;
    if (rst || raddr1 == '0 || !re1) begin
      rdata1 = '0;
    end else if (we && waddr == raddr1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = r_regs[raddr1];
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rdata2 = '0;
    if (rst || raddr2 == '0 || !re2) begin
      rdata2 = '0;
    end else if (we && waddr == raddr2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = r_regs[raddr2];
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
